// File: rtl/gi_recombine_pkg.sv
// Shared types and constants for the masked GF(2^4) inverse recombination stage.
// Monomial bit order: a, b, c, d, ab, ac, ad, bc, bd, cd, abc, abd, acd, bcd, abcd (a = nibble bit 3).
package gi_pkg;

    localparam int GI_NMONO = 15;

    localparam int GI_M_A    = 0;
    localparam int GI_M_B    = 1;
    localparam int GI_M_C    = 2;
    localparam int GI_M_D    = 3;
    localparam int GI_M_AB   = 4;
    localparam int GI_M_AC   = 5;
    localparam int GI_M_AD   = 6;
    localparam int GI_M_BC   = 7;
    localparam int GI_M_BD   = 8;
    localparam int GI_M_CD   = 9;
    localparam int GI_M_ABC  = 10;
    localparam int GI_M_ABD  = 11;
    localparam int GI_M_ACD  = 12;
    localparam int GI_M_BCD  = 13;
    localparam int GI_M_ABCD = 14;

    typedef logic [GI_NMONO-1:0]      gi_mono_t;
    typedef logic [3:0]               gi_nib_t;
    typedef logic [3:0][GI_NMONO-1:0] gi_anf_t;

    // Row i lists the monomials XORed into output bit i of x^-1 in GF(2^4) mod x^4+x+1.
    localparam gi_anf_t GI_INV_ANF = {
        15'h0477,   // y3 = a ^ b ^ c ^ ab ^ ac ^ ad ^ abc
        15'h0B43,   // y2 = a ^ b ^ ad ^ bd ^ cd ^ abd
        15'h13A1,   // y1 = a ^ ac ^ bc ^ bd ^ cd ^ acd
        15'h258F    // y0 = a ^ b ^ c ^ d ^ bc ^ bd ^ abc ^ bcd
    };
    localparam gi_nib_t GI_INV_CONST = 4'h0;

    function automatic gi_mono_t gi_mono_of(input gi_nib_t nib);
        logic a, b, c, d;
        gi_mono_t m;
        a = nib[3];
        b = nib[2];
        c = nib[1];
        d = nib[0];
        m            = '0;
        m[GI_M_A]    = a;
        m[GI_M_B]    = b;
        m[GI_M_C]    = c;
        m[GI_M_D]    = d;
        m[GI_M_AB]   = a & b;
        m[GI_M_AC]   = a & c;
        m[GI_M_AD]   = a & d;
        m[GI_M_BC]   = b & c;
        m[GI_M_BD]   = b & d;
        m[GI_M_CD]   = c & d;
        m[GI_M_ABC]  = a & b & c;
        m[GI_M_ABD]  = a & b & d;
        m[GI_M_ACD]  = a & c & d;
        m[GI_M_BCD]  = b & c & d;
        m[GI_M_ABCD] = a & b & c & d;
        return m;
    endfunction

endpackage

// File: rtl/gi_recombine_if.sv
// Valid/ready bus between the monomial expansion stage, gi_recombine and its consumer.
interface gi_recombine_if;
    import gi_pkg::*;

    logic     in_valid;
    logic     in_ready;
    gi_mono_t mono_sh0;
    gi_mono_t mono_sh1;
    logic     out_valid;
    logic     out_ready;
    gi_nib_t  out_sh0;
    gi_nib_t  out_sh1;

    modport master (
        output in_valid, mono_sh0, mono_sh1, out_ready,
        input  in_ready, out_valid, out_sh0, out_sh1
    );

    modport slave (
        input  in_valid, mono_sh0, mono_sh1, out_ready,
        output in_ready, out_valid, out_sh0, out_sh1
    );

endinterface

// File: rtl/gi_recombine_anf_eval.sv
// One share's linear compression of the 15 monomials into a 4-bit result, optional constant term.
module gi_anf_eval
    import gi_pkg::*;
#(
    parameter gi_anf_t ANF_COEF  = GI_INV_ANF,
    parameter gi_nib_t ANF_CONST = GI_INV_CONST,
    parameter bit      CONST_EN  = 1'b1
) (
    input  gi_mono_t mono,
    output gi_nib_t  y
);

    localparam gi_nib_t CONST_TERM = CONST_EN ? ANF_CONST : 4'h0;

    always_comb begin
        y = CONST_TERM;
        for (int i = 0; i < 4; i++) begin
            y[i] = y[i] ^ (^(ANF_COEF[i] & mono));
        end
    end

endmodule

// File: rtl/gi_recombine.sv
// Second stage of the two-share masked S-box: glitch-barrier register, per-share ANF compression, output register.
// Optional share refresh with fresh randomness is enabled by defining GI_RECOMBINE_REFRESH_EN.
module gi_recombine
    import gi_pkg::*;
#(
    parameter gi_anf_t ANF_COEF  = GI_INV_ANF,
    parameter gi_nib_t ANF_CONST = GI_INV_CONST
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef GI_RECOMBINE_REFRESH_EN
    input  gi_nib_t        rnd_ref,
`endif
    gi_recombine_if.slave  bus
);

    logic     s1_valid_q, s1_valid_d;
    gi_mono_t s1_sh0_q, s1_sh0_d;
    gi_mono_t s1_sh1_q, s1_sh1_d;
    logic     out_valid_q, out_valid_d;
    gi_nib_t  out_sh0_q, out_sh0_d;
    gi_nib_t  out_sh1_q, out_sh1_d;

    logic     s2_adv;
    logic     in_ready;
    logic     s1_load;
    logic     s2_load;
    gi_nib_t  y_sh0;
    gi_nib_t  y_sh1;
    gi_nib_t  refresh;

    assign s2_adv   = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = bus.in_valid && in_ready;
    assign s2_load  = s1_valid_q && s2_adv;

    // Shares are evaluated in separate instances so no logic combines them.
    gi_anf_eval #(
        .ANF_COEF  (ANF_COEF),
        .ANF_CONST (ANF_CONST),
        .CONST_EN  (1'b1)
    ) u_eval_sh0 (
        .mono (s1_sh0_q),
        .y    (y_sh0)
    );

    gi_anf_eval #(
        .ANF_COEF  (ANF_COEF),
        .ANF_CONST (ANF_CONST),
        .CONST_EN  (1'b0)
    ) u_eval_sh1 (
        .mono (s1_sh1_q),
        .y    (y_sh1)
    );

`ifdef GI_RECOMBINE_REFRESH_EN
    assign refresh = rnd_ref;
`else
    assign refresh = 4'h0;
`endif

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sh0_d    = s1_sh0_q;
        s1_sh1_d    = s1_sh1_q;
        out_valid_d = out_valid_q;
        out_sh0_d   = out_sh0_q;
        out_sh1_d   = out_sh1_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_sh0_d   = bus.mono_sh0;
            s1_sh1_d   = bus.mono_sh1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        // Same fresh bits on both shares keep the recombined value intact.
        if (s2_load) begin
            out_valid_d = 1'b1;
            out_sh0_d   = y_sh0 ^ refresh;
            out_sh1_d   = y_sh1 ^ refresh;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sh0_q    <= '0;
            s1_sh1_q    <= '0;
            out_valid_q <= 1'b0;
            out_sh0_q   <= '0;
            out_sh1_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sh0_q    <= s1_sh0_d;
            s1_sh1_q    <= s1_sh1_d;
            out_valid_q <= out_valid_d;
            out_sh0_q   <= out_sh0_d;
            out_sh1_q   <= out_sh1_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sh0   = out_sh0_q;
    assign bus.out_sh1   = out_sh1_q;

endmodule

// File: tb/tb_gi_recombine.sv
// Directed bench for gi_recombine: inverse sweep, random masks, back-pressure, back-to-back and mid-stream reset.
// With GI_RECOMBINE_REFRESH_EN defined, rnd_ref is tied to 4'hF and both shares are expected to carry it.
module tb_gi_recombine;
    import gi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    gi_recombine_if bus ();

`ifdef GI_RECOMBINE_REFRESH_EN
    gi_nib_t rnd_ref;
    localparam gi_nib_t RND = 4'hF;
`else
    localparam gi_nib_t RND = 4'h0;
`endif

    gi_recombine dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef GI_RECOMBINE_REFRESH_EN
        .rnd_ref (rnd_ref),
`endif
        .bus     (bus)
    );

    int check_count = 0;
    int pass_count  = 0;

    gi_nib_t vec_nib[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Hand-written inverse table for GF(2^4) mod x^4+x+1, 0 mapped to 0.
    function automatic gi_nib_t inv_ref(input gi_nib_t n);
        case (n)
            4'h0: return 4'h0;
            4'h1: return 4'h1;
            4'h2: return 4'h9;
            4'h3: return 4'hE;
            4'h4: return 4'hD;
            4'h5: return 4'hB;
            4'h6: return 4'h7;
            4'h7: return 4'h6;
            4'h8: return 4'hF;
            4'h9: return 4'h2;
            4'hA: return 4'hC;
            4'hB: return 4'h5;
            4'hC: return 4'hA;
            4'hD: return 4'h4;
            4'hE: return 4'h3;
            default: return 4'h8;
        endcase
    endfunction

    // Streams vec_nib through the DUT; out_ready is held low for the first stall_cycles cycles.
    task automatic applyStimulus(input string tag, input int stall_cycles, input bit masked, input bit expect_full);
        int       n = vec_nib.size();
        int       budget = 4 * n + 50;
        int       in_idx = 0;
        int       out_idx = 0;
        int       cyc = 0;
        bit       seen_stall = 1'b0;
        bit       held = 1'b0;
        bit       sh1_varies = 1'b0;
        gi_nib_t  prev_sh0 = 4'h0;
        gi_nib_t  prev_sh1 = 4'h0;
        gi_nib_t  first_sh1 = 4'h0;
        gi_mono_t mask;

        while (out_idx < n && cyc < budget) begin
            bus.out_ready = (cyc >= stall_cycles);
            if (in_idx < n) begin
                mask = masked ? 15'($urandom) : '0;
                bus.in_valid = 1'b1;
                bus.mono_sh0 = gi_mono_of(vec_nib[in_idx]) ^ mask;
                bus.mono_sh1 = mask;
            end else begin
                bus.in_valid = 1'b0;
                bus.mono_sh0 = '0;
                bus.mono_sh1 = '0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (masked) begin
                    checkOutput({tag, "_recomb"}, 32'(bus.out_sh0 ^ bus.out_sh1), 32'(inv_ref(vec_nib[out_idx])));
                    if (out_idx == 0) first_sh1 = bus.out_sh1;
                    else if (bus.out_sh1 != first_sh1) sh1_varies = 1'b1;
                end else begin
                    checkOutput({tag, "_sh0"}, 32'(bus.out_sh0), 32'(inv_ref(vec_nib[out_idx]) ^ RND));
                    checkOutput({tag, "_sh1"}, 32'(bus.out_sh1), 32'(RND));
                end
                out_idx++;
            end else if (bus.out_valid && held) begin
                checkOutput({tag, "_hold_sh0"}, 32'(bus.out_sh0), 32'(prev_sh0));
                checkOutput({tag, "_hold_sh1"}, 32'(bus.out_sh1), 32'(prev_sh1));
            end
            held     = bus.out_valid && !bus.out_ready;
            prev_sh0 = bus.out_sh0;
            prev_sh1 = bus.out_sh1;
            if (stall_cycles > 0 && !seen_stall && in_idx < n && !bus.in_ready) begin
                seen_stall = 1'b1;
                checkOutput({tag, "_accepts_at_stall"}, 32'(in_idx), 32'd2);
            end
            if (expect_full && in_idx < n) begin
                checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
            end
            if (bus.in_valid && bus.in_ready) in_idx++;
            cyc++;
            @(negedge clk);
        end

        checkOutput({tag, "_count"}, 32'(out_idx), 32'(n));
        if (expect_full) checkOutput({tag, "_cycles"}, 32'(cyc), 32'(n + 2));
        if (stall_cycles > 0) checkOutput({tag, "_stall_seen"}, 32'(seen_stall), 32'd1);
        if (masked) checkOutput({tag, "_sh1_varies"}, 32'(sh1_varies), 32'd1);
        bus.in_valid = 1'b0;
        #1;
        checkOutput({tag, "_no_dup"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mono_sh0  = '0;
        bus.mono_sh1  = '0;
        bus.out_ready = 1'b1;
`ifdef GI_RECOMBINE_REFRESH_EN
        rnd_ref       = RND;
`endif

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_sh0",   32'(bus.out_sh0),   32'd0);
        checkOutput("rst_out_sh1",   32'(bus.out_sh1),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] inverse sweep, zero masks");
        vec_nib.delete();
        for (int i = 0; i < 16; i++) vec_nib.push_back(gi_nib_t'(i));
        applyStimulus("sweep", 0, 1'b0, 1'b1);

        $display("[TB] random masks, nibble 2");
        vec_nib.delete();
        for (int i = 0; i < 1000; i++) vec_nib.push_back(4'h2);
        applyStimulus("mask", 0, 1'b1, 1'b1);

        $display("[TB] back-pressure, 5 vectors");
        vec_nib.delete();
        vec_nib.push_back(4'h3);
        vec_nib.push_back(4'h5);
        vec_nib.push_back(4'h8);
        vec_nib.push_back(4'hB);
        vec_nib.push_back(4'hE);
        applyStimulus("bp", 4, 1'b0, 1'b0);

        $display("[TB] back-to-back, 6 vectors");
        vec_nib.delete();
        vec_nib.push_back(4'hA);
        vec_nib.push_back(4'h6);
        vec_nib.push_back(4'hF);
        vec_nib.push_back(4'h1);
        vec_nib.push_back(4'hD);
        vec_nib.push_back(4'h4);
        applyStimulus("b2b", 0, 1'b0, 1'b1);

        $display("[TB] reset with two vectors in flight");
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.mono_sh0  = gi_mono_of(4'h7);
        bus.mono_sh1  = '0;
        @(negedge clk);
        bus.mono_sh0  = gi_mono_of(4'hC);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        #1;
        checkOutput("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre_rst_out_sh0",   32'(bus.out_sh0),   32'(4'h6 ^ RND));
        checkOutput("pre_rst_in_ready",  32'(bus.in_ready),  32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_out_sh0",   32'(bus.out_sh0),   32'd0);
        checkOutput("mid_rst_out_sh1",   32'(bus.out_sh1),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
            checkOutput("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/gi_recombine.md
# gi_recombine

Second stage of the two-stage masked AES S-box. Consumes the two-share masked monomial vector from the first-stage expansion (15 monomials of a 4-bit nibble {a,b,c,d}), and registers both shares as a glitch barrier. Each share is then compressed through a fixed ANF coefficient matrix into a 4-bit two-share result, by default the GF(2^4) inverse. A valid/ready pipeline with two register stages carries the data.

## Interface
- `ANF_COEF`, default `gi_pkg::GI_INV_ANF`: 4x15 bit matrix; row i selects the monomials XORed into output bit i.
- `ANF_CONST`, default `gi_pkg::GI_INV_CONST`: 4-bit constant term, added to share 0 only.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input vector valid.
- `in_ready` out 1: stage 1 can accept.
- `mono_sh0` in 15: masked monomials, bit order 0 a, 1 b, 2 c, 3 d, 4 ab, 5 ac, 6 ad, 7 bc, 8 bd, 9 cd, 10 abc, 11 abd, 12 acd, 13 bcd, 14 abcd (a = nibble bit 3).
- `mono_sh1` in 15: mask share (the first-stage random vector).
- `rnd_ref` in 4: fresh refresh randomness, sampled with the stage-1 to stage-2 transfer. Present only with the macro.
- `out_valid` out 1: output shares valid.
- `out_ready` in 1: downstream accepts.
- `out_sh0` out 4: result share 0.
- `out_sh1` out 4: result share 1.

## Operation
- Stage 1 (S1) registers `mono_sh0`/`mono_sh1` unmodified. No logic mixes shares before this register.
- Stage 2 (S2) computes per share, independently:
  - `y_sh0[i] = XOR_j(ANF_COEF[i][j] & s1_sh0[j]) ^ ANF_CONST[i]`
  - `y_sh1[i] = XOR_j(ANF_COEF[i][j] & s1_sh1[j])`
  - With refresh, `rnd_ref` is XORed into both shares, then registered to `out_sh*`.
- Invariant: `out_sh0 ^ out_sh1 = F(nibble)`, where nibble = XOR-recombined bits 3..0 of the input shares.
- Handshake:
  - Transfer on valid & ready at each boundary.
  - `out_valid` stays high and `out_sh*` stay stable until `out_ready`.
  - `in_valid` may drop without transfer.
- Pipeline advance:
  - `s2_adv = !out_valid_q | out_ready`
  - `in_ready = !s1_valid_q | s2_adv`, combinational from `out_ready`.
- S1 and S2 may both accept in the same cycle: full throughput of one vector per clock.
- Stage registers load only on transfer. With `s1_valid_q=0`, S2 loads nothing; `out_valid` clears after being consumed.

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream) clears:
  - `s1_valid_q=0`, `out_valid=0`, `out_sh0=0`, `out_sh1=0`
  - S1 data registers = 0
  - `in_ready` reads 1 after reset.
- Latency: input accepted at edge N appears on `out_*` after edge N+1 (2 registers), with `out_ready` held high.
- Back-pressure: with `out_ready=0`, S1 holds one more vector, then `in_ready=0`. Buffering is at most 2 vectors; nothing is dropped or duplicated.
- Reset mid-stream: all in-flight vectors are discarded and `out_valid` falls immediately (asynchronous).
- `rnd_ref` is consumed only on cycles where S2 loads.

## Configuration
- `GI_RECOMBINE_REFRESH_EN` defined:
  - The `rnd_ref` port exists.
  - Both output shares are refreshed with the same 4 fresh bits, so the unmasked value is unchanged.
- Not defined:
  - The port is absent.
  - Shares leave S2 unrefreshed.
  - Latency and handshake are identical.

## Structure
- `gi_pkg` holds:
  - monomial index localparams (`GI_M_A` .. `GI_M_ABCD`)
  - `GI_NMONO=15`
  - `GI_INV_ANF` (4x15), `GI_INV_CONST`: ANF of GF(2^4) inverse mod x^4+x+1, 0 mapped to 0
  - typedef `gi_mono_t` (15-bit), `gi_nib_t` (4-bit)
- One combinational sub-module, `gi_anf_eval`: one share's 15-to-4 linear layer plus optional constant. Instantiated twice, with the constant disabled for share 1.

## Test plan
- Zero masks, `out_ready=1`, each nibble 0..15 fed as its monomial vector -> two cycles later `out_sh0^out_sh1` = inverse: 0->0, 1->1, 2->9, others per table.
- Random 15-bit `mono_sh1`, `mono_sh0` = monomials XOR mask, nibble 4'h2 -> recombined output 4'h9 for 1000 random masks. Share 1 alone is not constant.
- Back-pressure: stream 5 vectors, `out_ready=0` for 4 cycles ->
  - `in_ready` falls after 2 accepts
  - `out_sh*` hold steady
  - all 5 results emerge in order with no loss or duplication.
- Back-to-back with `out_ready=1` -> one result per cycle, `in_ready` constantly 1.
- Assert `rst_n` low with 2 vectors in flight -> `out_valid=0` and `out_sh*=0` immediately; after release, `in_ready=1` and no stale output.
- Macro on, `rnd_ref=4'hF` -> each share differs from the macro-off run by 4'hF; recombined value is unchanged.
